// File: rtl/rate_divider_pkg.sv
// Shared constants and the rate-select -> divisor rule for the rate divider.
package rate_divider_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  // Rate 0 is full speed; higher selects halve the slowest rate fewer times.
  // A result that truncates to zero is clamped to one.
  function automatic int unsigned rate_divisor(input int unsigned sel,
                                               input int unsigned clk_hz,
                                               input int unsigned sel_w);
    int unsigned d;
    if (sel == 0) d = 1;
    else          d = clk_hz >> ((1 << sel_w) - 1 - sel);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/rate_select_decode.sv
// Combinational rate select -> (divisor - 1) reload value for the down-counter.
module rate_select_decode
  import rate_divider_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 26
) (
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] div_m1
);

  always_comb begin
    div_m1 = CNT_W'(rate_divisor(32'(sel), CLK_HZ, SEL_W) - 32'd1);
  end

endmodule

// File: rtl/rate_divider_counter.sv
// Programmable rate divider: one-cycle tick per period plus wrapping event counter.
// Optional macro RATE_DIVIDER_IMMEDIATE_RELOAD_EN applies rate changes mid-period.
module rate_divider_counter
  import rate_divider_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned OUT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [SEL_W-1:0] rate_sel,
  output logic             tick,
  output logic [OUT_W-1:0] value,
  output logic [SEL_W-1:0] active_rate,
  output logic             rate_ack
);

  // Clamp keeps a legal width when CLK_HZ is 1.
  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] sel_div_m1, act_div_m1;

  rate_select_decode #(.CLK_HZ(CLK_HZ), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_sel_dec (
    .sel    (rate_sel),
    .div_m1 (sel_div_m1)
  );

  // Second decoder supplies the reload used by clear, which keeps the current rate.
  rate_select_decode #(.CLK_HZ(CLK_HZ), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_act_dec (
    .sel    (active_q),
    .div_m1 (act_div_m1)
  );

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    value_d  = value_q;
    tick_d   = 1'b0;
    ack_d    = 1'b0;
    if (clear) begin
      value_d = '0;
      count_d = act_div_m1;
    end else if (enable) begin
      if (count_q == '0) begin
        count_d  = sel_div_m1;
        active_d = rate_sel;
        tick_d   = 1'b1;
        value_d  = value_q + 1'b1;
        ack_d    = (rate_sel != active_q);
      end
`ifdef RATE_DIVIDER_IMMEDIATE_RELOAD_EN
      else if (rate_sel != active_q) begin
        count_d  = sel_div_m1;
        active_d = rate_sel;
        ack_d    = 1'b1;
      end
`endif
      else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= '0;
      value_q  <= '0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      value_q  <= value_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
    end
  end

  assign tick        = tick_q;
  assign value       = value_q;
  assign active_rate = active_q;
  assign rate_ack    = ack_q;

endmodule

// File: tb/tb_rate_divider_counter.sv
// Randomized bench for rate_divider_counter against a period/phase reference model.
module tb_rate_divider_counter;

  localparam int unsigned CLK_HZ = 16;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned OUT_W  = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             clear = 1'b0;
  logic [SEL_W-1:0] rate_sel = '0;
  logic             tick;
  logic [OUT_W-1:0] value;
  logic [SEL_W-1:0] active_rate;
  logic             rate_ack;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: period length, position in period, and output images.
  int m_plen, m_pos, m_val, m_act, m_tick, m_ack;

  rate_divider_counter #(.CLK_HZ(CLK_HZ), .SEL_W(SEL_W), .OUT_W(OUT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .rate_sel    (rate_sel),
    .tick        (tick),
    .value       (value),
    .active_rate (active_rate),
    .rate_ack    (rate_ack)
  );

  always #5 clock = ~clock;

  // Divisors for CLK_HZ=16: 1, 4, 8, 16.
  function automatic int divisor(input int k);
    if (k == 0) return 1;
    return CLK_HZ / (1 << (3 - k));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_plen = 1; m_pos = 0; m_val = 0; m_act = 0; m_tick = 0; m_ack = 0;
  endtask

  task automatic model_step();
    int sel;
    sel = int'(rate_sel);
    m_tick = 0;
    m_ack  = 0;
    if (clear) begin
      m_val = 0;
      m_pos = 0;
      m_plen = divisor(m_act);
    end else if (enable) begin
      if (m_pos == m_plen - 1) begin
        m_tick = 1;
        m_val  = (m_val + 1) % (1 << OUT_W);
        m_ack  = (sel != m_act);
        m_act  = sel;
        m_plen = divisor(sel);
        m_pos  = 0;
      end
`ifdef RATE_DIVIDER_IMMEDIATE_RELOAD_EN
      else if (sel != m_act) begin
        m_act  = sel;
        m_plen = divisor(sel);
        m_pos  = 0;
        m_ack  = 1;
      end
`endif
      else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".tick"},  int'(tick),        m_tick);
    chk({tag, ".value"}, int'(value),       m_val);
    chk({tag, ".rate"},  int'(active_rate), m_act);
    chk({tag, ".ack"},   int'(rate_ack),    m_ack);
  endtask

  // Inputs are stable here; advance model, clock DUT, compare 1 time unit later.
  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Full-speed rate: tick every cycle.
    enable = 1'b1;
    rate_sel = 0;
    repeat (20) step("rate0");

    // Rate 1 held long enough to wrap the event counter.
    rate_sel = 1;
    repeat (70) step("rate1");

    // Mid-period switch 3 -> 1 at count 10 (position 5 of 16).
    rate_sel = 3;
    for (int i = 0; i < 40 && !(m_plen == 16 && m_pos == 5); i++) step("to_rate3");
    chk("mid_setup", m_pos, 5);
    rate_sel = 1;
    repeat (24) step("mid_switch");

    // Freeze for 5 cycles mid-period at rate 2, with rate_sel wiggling.
    rate_sel = 2;
    for (int i = 0; i < 40 && !(m_plen == 8 && m_pos == 3); i++) step("to_rate2");
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rate_sel = SEL_W'(i);
      step("frozen");
    end
    rate_sel = 2;
    enable = 1'b1;
    repeat (16) step("unfreeze");

    // Clear on a terminal-count cycle.
    for (int i = 0; i < 20 && m_pos != m_plen - 1; i++) step("to_tc");
    clear = 1'b1;
    step("clear_tc");
    clear = 1'b0;
    repeat (12) step("after_clear");

    // Asynchronous reset between edges at rate 3, count 7.
    rate_sel = 3;
    for (int i = 0; i < 60 && !(m_plen == 16 && m_pos == 8); i++) step("to_rst");
    chk("rst_setup", m_pos, 8);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) step("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 14) == 0) rate_sel = SEL_W'($urandom_range(0, 3));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
